// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with blanking gap and frame-synchronous reload.
// Optional leading-zero blanking when SEG_LZB_EN is defined.
module seg_scan_ctrl #(
   parameter int DIGITS    = 4,
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [4*DIGITS-1:0] val_in,
   input  logic [DIGITS-1:0]   dp_in,
   input  logic                load,
   output logic                load_ack,
   output logic [DIGITS-1:0]   dig_sel,
   output logic [8:0]          seg_out,
   output logic                frame_done
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(DIGITS);
   localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYC - 1);
   localparam logic [CW-1:0] DRV_LAST = CW'(SCAN_DIV - BLANK_CYC - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

   state_t              state, state_n;
   logic [CW-1:0]       cnt, cnt_n;
   logic [IW-1:0]       idx, idx_n;
   logic                wrap, xfer, lzb;
   logic [4*DIGITS-1:0] stage_val, shadow_val;
   logic [DIGITS-1:0]   stage_dp, shadow_dp;
   logic                pend;
   logic [DIGITS-1:0]   dig_n;
   logic [8:0]          seg_n;
   logic [3:0]          nib;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      unique case (n)
         4'h0: hex7 = 7'h3f;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5b;
         4'h3: hex7 = 7'h4f;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6d;
         4'h6: hex7 = 7'h7d;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7f;
         4'h9: hex7 = 7'h6f;
         4'ha: hex7 = 7'h77;
         4'hb: hex7 = 7'h7c;
         4'hc: hex7 = 7'h39;
         4'hd: hex7 = 7'h5e;
         4'he: hex7 = 7'h79;
         4'hf: hex7 = 7'h71;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      idx_n   = idx;
      wrap    = 1'b0;
      if (!en) begin
         state_n = IDLE;
         cnt_n   = '0;
         idx_n   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               state_n = BLANK;
               cnt_n   = '0;
               idx_n   = '0;
            end
            BLANK: begin
               if (cnt == BLK_LAST) begin
                  state_n = DRIVE;
                  cnt_n   = '0;
               end
            end
            DRIVE: begin
               if (cnt == DRV_LAST) begin
                  state_n = BLANK;
                  cnt_n   = '0;
                  if (idx == IDX_LAST) begin
                     idx_n = '0;
                     wrap  = 1'b1;
                  end else begin
                     idx_n = idx + 1'b1;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Shadow only reloads while dark: from IDLE or on the frame wrap edge.
   assign xfer = pend && (state == IDLE || wrap);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_val  <= '0;
         stage_dp   <= '0;
         pend       <= 1'b0;
         shadow_val <= '0;
         shadow_dp  <= '0;
      end else begin
         if (xfer) begin
            shadow_val <= stage_val;
            shadow_dp  <= stage_dp;
         end
         if (load) begin
            stage_val <= val_in;
            stage_dp  <= dp_in;
            pend      <= 1'b1;
         end else if (xfer) begin
            pend <= 1'b0;
         end
      end
   end

   assign nib = shadow_val[{idx_n, 2'b00} +: 4];

`ifdef SEG_LZB_EN
   logic [DIGITS-1:0] zhi;
   logic              acc;

   always_comb begin
      zhi = '0;
      acc = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         acc    = acc & (shadow_val[4*i +: 4] == 4'h0);
         zhi[i] = acc;
      end
   end

   assign lzb = (idx_n != '0) && zhi[idx_n];
`else
   assign lzb = 1'b0;
`endif

   // Outputs are registered from the state being entered.
   always_comb begin
      dig_n = '1;
      seg_n = '0;
      if (state_n == DRIVE) begin
         dig_n[idx_n] = 1'b0;
         seg_n = {1'b0, shadow_dp[idx_n], lzb ? 7'h00 : hex7(nib)};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dig_sel    <= '1;
         seg_out    <= '0;
         load_ack   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         dig_sel    <= dig_n;
         seg_out    <= seg_n;
         load_ack   <= xfer;
         frame_done <= wrap;
      end
   end

endmodule
